// File: rtl/vga_display_gen.sv
`timescale 1ns/1ps
// VGA scan timing generator and 2-bit pixel colouriser for the bot's pixel interface.
// Sync, blank and RGB lag vid_row/vid_col by PIX_LATENCY+1 pixel ticks; free-running, no backpressure.
module vga_display_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] vid_pixel_in,
    output logic [9:0] vid_row,
    output logic [9:0] vid_col,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tick_q;
    logic [9:0]             hcount_q, hcount_d;
    logic [9:0]             vcount_q, vcount_d;
    logic                   frame_q;
    logic                   h_wrap, v_wrap;
    logic                   act_raw, hs_raw, vs_raw;
    logic [PIX_LATENCY:0]   act_ext, hs_ext, vs_ext;
    logic [PIX_LATENCY-1:0] act_sr_q, act_sr_d;
    logic [PIX_LATENCY-1:0] hs_sr_q, hs_sr_d;
    logic [PIX_LATENCY-1:0] vs_sr_q, vs_sr_d;
    logic                   von_q, hs_q, vs_q;
    logic [7:0]             rgb_q, rgb_d;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick_q) begin
            hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
            if (h_wrap) begin
                vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
            end
        end

        act_raw = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        hs_raw  = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
        vs_raw  = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));

        // Stage 0 takes the coordinate the bot is currently being shown.
        act_ext  = {act_sr_q, act_raw};
        hs_ext   = {hs_sr_q, hs_raw};
        vs_ext   = {vs_sr_q, vs_raw};
        act_sr_d = act_ext[PIX_LATENCY-1:0];
        hs_sr_d  = hs_ext[PIX_LATENCY-1:0];
        vs_sr_d  = vs_ext[PIX_LATENCY-1:0];

        rgb_d = 8'h00;
        if (act_sr_q[PIX_LATENCY-1]) begin
            case (vid_pixel_in)
                2'b00:   rgb_d = 8'hFF;
                2'b01:   rgb_d = 8'h00;
                2'b10:   rgb_d = 8'hE0;
                default: rgb_d = 8'h03;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            frame_q  <= 1'b0;
            act_sr_q <= '0;
            hs_sr_q  <= '1;
            vs_sr_q  <= '1;
            von_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= 8'h00;
        end else begin
            div_q   <= div_d;
            tick_q  <= (div_q == DIV_LAST);
            frame_q <= tick_q && h_wrap && v_wrap;
            if (tick_q) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                act_sr_q <= act_sr_d;
                hs_sr_q  <= hs_sr_d;
                vs_sr_q  <= vs_sr_d;
                von_q    <= act_sr_q[PIX_LATENCY-1];
                hs_q     <= hs_sr_q[PIX_LATENCY-1];
                vs_q     <= vs_sr_q[PIX_LATENCY-1];
                rgb_q    <= rgb_d;
            end
        end
    end

    assign vid_row     = vcount_q;
    assign vid_col     = hcount_q;
    assign pix_tick    = tick_q;
    assign frame_start = frame_q;
    assign video_on    = von_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign {vga_red, vga_green, vga_blue} = rgb_q;

endmodule

// File: doc/vga_display_gen.md
Name: vga_display_gen

Overview:
- Display timing generator and colouriser for the Nexys3 VGA port. Sits at the video end of the bot's pixel interface.
- Produces the vid_row/vid_col scan coordinates that the bot's world/icon logic consumes.
- Samples the 2-bit vid_pixel_out code the bot returns and drives hsync/vsync and 8-bit RGB.
- Timing is 640x480 at 60 Hz from the 100 MHz system clock, with a 25 MHz pixel enable.

Parameters:
- CLK_DIV, 4: system clocks per pixel.
- H_ACTIVE, 640: visible columns.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: hsync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible rows.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vsync width (lines).
- V_BP, 33: vertical back porch (lines).
- PIX_LATENCY, 1: pixel ticks between vid_row/vid_col presentation and a valid vid_pixel_in; range 1..4.

Ports:
- clk, input, 1: 100 MHz system clock.
- reset, input, 1: synchronous, active-low reset.
- vid_pixel_in, input, 2: pixel code from the bot (00 background, 01 line, 10 obstruction, 11 icon).
- vid_row, output, 10: current scan line (raw counter, 0..524).
- vid_col, output, 10: current scan column (raw counter, 0..799).
- pix_tick, output, 1: one-clk pixel enable pulse.
- frame_start, output, 1: one-clk pulse at scan position (0,0).
- video_on, output, 1: delayed active-video flag, aligned with the RGB outputs.
- hsync, output, 1: horizontal sync, active low.
- vsync, output, 1: vertical sync, active low.
- vga_red, output, 3: red.
- vga_green, output, 3: green.
- vga_blue, output, 2: blue.

Behaviour:
- Reset:
  - Applied on any clk edge with reset==0, including mid-frame; no partial-line state survives.
  - Divider, hcount and vcount go to 0.
  - pix_tick, frame_start and video_on go to 0.
  - hsync and vsync go to 1 (deasserted).
  - RGB goes to 0.
  - The delay pipeline is cleared to blank/deasserted.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_tick=1 for exactly one clk, when div==CLK_DIV-1. First pix_tick is CLK_DIV clks after reset release.
- Horizontal counter: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800. hcount advances only on pix_tick and wraps 799->0.
- Vertical counter: V_TOTAL=525. vcount advances on the pix_tick where hcount wraps, and wraps 524->0 on the same tick.
- vid_col/vid_row: equal hcount/vcount and are registered; they change only in the clk after pix_tick.
- frame_start: 1 for one clk, in the same clk the counters become (0,0).
- Raw timing:
  - active = (hcount<640) && (vcount<480).
  - hsync_raw = 0 when 656<=hcount<=751.
  - vsync_raw = 0 when 490<=vcount<=491.
- Alignment pipeline:
  - active, hsync_raw and vsync_raw pass through a PIX_LATENCY-deep shift register that advances on pix_tick only.
  - The outputs video_on, hsync and vsync are the registered last stage.
  - Between ticks all outputs hold.
- Colouriser:
  - On each pix_tick, vid_pixel_in is sampled and {vga_red,vga_green,vga_blue} is registered.
  - If the delayed active is 0, RGB = 8'h00 regardless of vid_pixel_in.
  - If the delayed active is 1, the mapping is:
    - 00 -> 8'hFF (white)
    - 01 -> 8'h00 (black)
    - 10 -> 8'hE0 (red)
    - 11 -> 8'h03 (blue)
- Alignment rule: RGB for coordinate (r,c) appears PIX_LATENCY+1 ticks after vid_row/vid_col present (r,c). hsync and vsync shift by the same amount, so the porch widths are preserved exactly.
- Boundary conditions:
  - Last visible pixel (639,479) is coloured.
  - Column 640 and row 480 onward are blanked.
  - The vsync edge coincides with the pix_tick that starts line 490 (after delay).
- Arithmetic: counters are 10 bits unsigned. No value ever exceeds 799, so no overflow.

Test Plan:
- Reset: hold reset=0 for 10 clks, release -> hsync=vsync=1, RGB=0, vid_row=vid_col=0; first pix_tick exactly 4 clks later, then every 4 clks.
- Line timing: run 1 line -> hsync low for exactly 96 ticks (384 clks), beginning 656+PIX_LATENCY+1 ticks after hcount=0; line period 800 ticks = 3200 clks.
- Frame timing: run 2 frames -> vsync low for 2 lines (1600 ticks); frame period 420000 ticks; frame_start pulses once per frame, one clk wide, when vid_row=vid_col=0.
- Colour map: drive vid_pixel_in = 00,01,10,11 at col 10 row 10 -> RGB FF,00,E0,03 respectively, appearing PIX_LATENCY+1 ticks later.
- Blanking: hold vid_pixel_in=00 during col 640..799 and rows 480..524 -> RGB=00; col 639 row 479 -> FF.
- Mid-frame reset: assert reset at row 200 col 300 for 1 clk -> next clk counters=0, hsync=vsync=1, RGB=0; normal timing resumes after release.
